// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Brief    : Parametrised multi-read, dual-write register file with
//             write-first read bypass, optional hardwired zero register,
//             sequential clear engine and per-register pending scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       clear_in,
    output logic                       ready_out,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_in,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_out,
    output logic [NUM_RD-1:0]          rd_pend_out,
    input  logic                       wr0_en_in,
    input  logic [ADDR_W-1:0]          wr0_addr_in,
    input  logic [DATA_W-1:0]          wr0_data_in,
    input  logic                       wr1_en_in,
    input  logic [ADDR_W-1:0]          wr1_addr_in,
    input  logic [DATA_W-1:0]          wr1_data_in,
    input  logic                       issue_en_in,
    input  logic [ADDR_W-1:0]          issue_addr_in
);

    localparam int               c_DEPTH    = 1 << ADDR_W;
    localparam bit               c_ZERO     = (ZERO_REG != 0);
    // Clear index is one bit wider than an address so it never wraps
    // before the last entry has been recognised.
    localparam logic [ADDR_W:0]  c_CLR_LAST = (ADDR_W+1)'(c_DEPTH - 1);
    localparam logic [ADDR_W:0]  c_IDX_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_W:0]        r_clr_idx;
    logic [DATA_W-1:0]      r_mem [c_DEPTH];
    logic [c_DEPTH-1:0]     r_pend;
    logic [c_DEPTH-1:0]     w_pend_nxt;

    logic                   w_ready;
    logic                   w_update;
    logic                   w_wr0_ok;
    logic                   w_wr1_ok;

    assign w_ready  = (r_state == ST_READY);
    // Architectural updates only happen in READY when no clear is requested.
    assign w_update = w_ready && !clear_in;
    // The zero register (when enabled) silently drops writes.
    assign w_wr0_ok = wr0_en_in && !(c_ZERO && (wr0_addr_in == '0));
    assign w_wr1_ok = wr1_en_in && !(c_ZERO && (wr1_addr_in == '0));

    // Clear engine / state machine with registered ready flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            ready_out <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (clear_in) begin
                        r_clr_idx <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_IDX_ONE;
                        if (r_clr_idx == c_CLR_LAST) begin
                            r_state   <= ST_READY;
                            ready_out <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (clear_in) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                        ready_out <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_idx <= '0;
                    ready_out <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear engine zeroes one entry per edge, otherwise the
    // two retire ports write in order so port 1 wins on an address clash.
    always_ff @(posedge clk_in) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx[ADDR_W-1:0]] <= '0;
        end else if (w_update) begin
            if (w_wr0_ok) begin
                r_mem[wr0_addr_in] <= wr0_data_in;
            end
            if (w_wr1_ok) begin
                r_mem[wr1_addr_in] <= wr1_data_in;
            end
        end
    end

    // Next scoreboard value: retiring writes clear, a new issue sets last so
    // that a fresh producer supersedes the one retiring on the same edge.
    always_comb begin
        w_pend_nxt = r_pend;
        if (wr0_en_in) begin
            w_pend_nxt[wr0_addr_in] = 1'b0;
        end
        if (wr1_en_in) begin
            w_pend_nxt[wr1_addr_in] = 1'b0;
        end
        if (issue_en_in) begin
            w_pend_nxt[issue_addr_in] = 1'b1;
        end
        if (c_ZERO) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    // Scoreboard register, wiped on reset, during clear and on a clear request.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pend <= '0;
        end else if (!w_update) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Read ports: write-first bypass, zero register, and gated during clear.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr_in[k*ADDR_W +: ADDR_W];

        // Select the visible value for this port's address.
        always_comb begin
            w_data = r_mem[w_addr];
            if (!w_ready) begin
                w_data = '0;
            end else if (c_ZERO && (w_addr == '0)) begin
                w_data = '0;
            end else if (wr1_en_in && (wr1_addr_in == w_addr)) begin
                w_data = wr1_data_in;
            end else if (wr0_en_in && (wr0_addr_in == w_addr)) begin
                w_data = wr0_data_in;
            end
        end

        assign rd_data_out[k*DATA_W +: DATA_W] = w_data;
        assign rd_pend_out[k] = w_ready && r_pend[w_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp_sb
//  Brief    : Self-checking bench for regfile_mp_sb (directed table,
//             clear/reset sequences, randomized traffic vs. reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk_in = 1'b0;
    logic                     rst_n_in;
    logic                     clear_in;
    logic                     ready_out;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_in;
    logic [NUM_RD*DATA_W-1:0] rd_data_out;
    logic [NUM_RD-1:0]        rd_pend_out;
    logic                     wr0_en_in;
    logic [ADDR_W-1:0]        wr0_addr_in;
    logic [DATA_W-1:0]        wr0_data_in;
    logic                     wr1_en_in;
    logic [ADDR_W-1:0]        wr1_addr_in;
    logic [DATA_W-1:0]        wr1_data_in;
    logic                     issue_en_in;
    logic [ADDR_W-1:0]        issue_addr_in;

    regfile_mp_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .clear_in      (clear_in),
        .ready_out     (ready_out),
        .rd_addr_in    (rd_addr_in),
        .rd_data_out   (rd_data_out),
        .rd_pend_out   (rd_pend_out),
        .wr0_en_in     (wr0_en_in),
        .wr0_addr_in   (wr0_addr_in),
        .wr0_data_in   (wr0_data_in),
        .wr1_en_in     (wr1_en_in),
        .wr1_addr_in   (wr1_addr_in),
        .wr1_data_in   (wr1_data_in),
        .issue_en_in   (issue_en_in),
        .issue_addr_in (issue_addr_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural contents, pending set, ready flag and
    // number of edges still needed before the file becomes usable.
    logic [DATA_W-1:0] m_mem  [DEPTH];
    bit                m_pend [DEPTH];
    bit                m_ready;
    int                m_left;

    typedef struct {
        logic              w0e;
        logic [ADDR_W-1:0] w0a;
        logic [DATA_W-1:0] w0d;
        logic              w1e;
        logic [ADDR_W-1:0] w1a;
        logic [DATA_W-1:0] w1d;
        logic              ie;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] ra0;
        logic [ADDR_W-1:0] ra1;
        logic [DATA_W-1:0] ed0;
        logic [DATA_W-1:0] ed1;
        logic              ep0;
        logic              ep1;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = DEPTH;
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        model_clear_all();
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (!m_ready || a == '0)                 return '0;
        if (wr1_en_in && wr1_addr_in == a)       return wr1_data_in;
        if (wr0_en_in && wr0_addr_in == a)       return wr0_data_in;
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
        return m_ready && m_pend[a];
    endfunction

    // Compare all combinational outputs against the model.
    task automatic check_model();
        logic [ADDR_W-1:0] a;
        chk("ready_out", 32'(ready_out), 32'(m_ready));
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr_in[k*ADDR_W +: ADDR_W];
            chk($sformatf("rd_data[%0d] x%0d", k, a), rd_data_out[k*DATA_W +: DATA_W], exp_data(a));
            chk($sformatf("rd_pend[%0d] x%0d", k, a), 32'(rd_pend_out[k]), 32'(exp_pend(a)));
        end
    endtask

    // Apply the effect of one rising edge to the model.
    task automatic model_edge();
        if (!m_ready) begin
            if (clear_in) begin
                m_left = DEPTH;
            end else begin
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end
        end else if (clear_in) begin
            m_ready = 1'b0;
            model_clear_all();
        end else begin
            if (wr0_en_in && wr0_addr_in != '0) m_mem[wr0_addr_in] = wr0_data_in;
            if (wr1_en_in && wr1_addr_in != '0) m_mem[wr1_addr_in] = wr1_data_in;
            if (wr0_en_in)   m_pend[wr0_addr_in]   = 1'b0;
            if (wr1_en_in)   m_pend[wr1_addr_in]   = 1'b0;
            if (issue_en_in) m_pend[issue_addr_in] = 1'b1;
            m_pend[0] = 1'b0;
        end
    endtask

    task automatic idle();
        clear_in    = 1'b0;
        wr0_en_in   = 1'b0;
        wr0_addr_in = '0;
        wr0_data_in = '0;
        wr1_en_in   = 1'b0;
        wr1_addr_in = '0;
        wr1_data_in = '0;
        issue_en_in = 1'b0;
        issue_addr_in = '0;
        rd_addr_in  = NUM_RD*ADDR_W'($urandom);
    endtask

    // Inputs are driven just after a falling edge; check, clock, update model.
    task automatic tick();
        #2;
        check_model();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    // Run idle cycles until ready, returning the number of edges taken.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (!ready_out && edges < 100) begin
            idle();
            tick();
            edges++;
        end
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 3));
        return ADDR_W'($urandom_range(0, DEPTH-1));
    endfunction

    initial begin
        int edges;

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0, 32'h22,       32'h0,        1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd0, 5'd9, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd5, 5'd9, 32'hDEADBEEF, 32'h99,       1'b0, 1'b1};
        tbl[6] = '{1'b1, 5'd9, 32'h123,      1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 32'h123,      32'h123,      1'b0, 1'b0};
        tbl[7] = '{1'b1, 5'd3, 32'hA5,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3, 32'h123,      32'hA5,       1'b1, 1'b0};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd9, 32'hA5,       32'h123,      1'b0, 1'b1};

        // Power-on reset and initial clear.
        rst_n_in = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk_in);
        #2;
        chk("ready_in_reset", 32'(ready_out), 32'd0);
        chk("pend_in_reset", 32'(rd_pend_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_ready(edges);
        chk("reset_clear_edges", 32'(edges), 32'd32);

        // Directed table in READY.
        for (int i = 0; i < 9; i++) begin
            wr0_en_in     = tbl[i].w0e;
            wr0_addr_in   = tbl[i].w0a;
            wr0_data_in   = tbl[i].w0d;
            wr1_en_in     = tbl[i].w1e;
            wr1_addr_in   = tbl[i].w1a;
            wr1_data_in   = tbl[i].w1d;
            issue_en_in   = tbl[i].ie;
            issue_addr_in = tbl[i].ia;
            clear_in      = 1'b0;
            rd_addr_in    = {tbl[i].ra1, tbl[i].ra0};
            #1;
            chk($sformatf("tbl%0d rd_data0", i), rd_data_out[DATA_W-1:0], tbl[i].ed0);
            chk($sformatf("tbl%0d rd_data1", i), rd_data_out[2*DATA_W-1:DATA_W], tbl[i].ed1);
            chk($sformatf("tbl%0d rd_pend0", i), 32'(rd_pend_out[0]), 32'(tbl[i].ep0));
            chk($sformatf("tbl%0d rd_pend1", i), 32'(rd_pend_out[1]), 32'(tbl[i].ep1));
            tick();
        end

        // Clear request: writes and issues ignored for 32 edges.
        idle();
        clear_in = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            wr0_en_in     = 1'b1;
            wr0_addr_in   = 5'd3;
            wr0_data_in   = 32'h77;
            issue_en_in   = 1'b1;
            issue_addr_in = 5'd3;
            rd_addr_in    = {5'd9, 5'd3};
            #1;
            chk($sformatf("clear_ready_low e%0d", i), 32'(ready_out), 32'd0);
            tick();
        end
        idle();
        rd_addr_in = {5'd9, 5'd3};
        #1;
        chk("clear_ready_high", 32'(ready_out), 32'd1);
        chk("clear_x3_zero", rd_data_out[DATA_W-1:0], 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_in = {ADDR_W'(a), ADDR_W'(a)};
            #1;
            chk($sformatf("clear_pend x%0d", a), 32'(rd_pend_out), 32'd0);
            chk($sformatf("clear_data x%0d", a), rd_data_out[DATA_W-1:0], 32'd0);
        end
        tick();

        // Reset mid-clear at clear index 10.
        idle();
        clear_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            idle();
            tick();
        end
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("midclear_reset_ready", 32'(ready_out), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        wait_ready(edges);
        chk("midclear_restart_edges", 32'(edges), 32'd32);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            idle();
            clear_in      = ($urandom_range(0, 79) == 0);
            wr0_en_in     = $urandom_range(0, 1) == 1;
            wr0_addr_in   = pick_addr();
            wr0_data_in   = $urandom;
            wr1_en_in     = $urandom_range(0, 2) == 0;
            wr1_addr_in   = ($urandom_range(0, 3) == 0) ? wr0_addr_in : pick_addr();
            wr1_data_in   = $urandom;
            issue_en_in   = $urandom_range(0, 1) == 1;
            issue_addr_in = ($urandom_range(0, 3) == 0) ? wr0_addr_in : pick_addr();
            rd_addr_in    = {pick_addr(), ($urandom_range(0, 2) == 0) ? wr0_addr_in : pick_addr()};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
